// File: rtl/adc_bcd_pkg.sv
// Shared types and defaults for the ADC sample to X.XXX volt BCD path.
// Holds the converter FSM encoding and the default widths and reference.
package adc_bcd_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SCALE   = 2'd1,
    CONVERT = 2'd2,
    DONE    = 2'd3
  } conv_state_t;

  localparam int ADC_W_DEF   = 12;
  localparam int MV_W_DEF    = 14;
  localparam int VREF_MV_DEF = 5000;
  localparam int BCD_DIGITS  = 4;

endpackage

// File: rtl/bin2bcd_seq.sv
// Iterative double-dabble: one bit of bin_in per cycle, MSB first, MV_W cycles after start.
// bin_in must stay stable while converting; done is high during the last conversion cycle.
module bin2bcd_seq
  import adc_bcd_pkg::*;
#(
  parameter int MV_W = MV_W_DEF
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    start,
  input  logic [MV_W-1:0]         bin_in,
  output logic [4*BCD_DIGITS-1:0] bcd_out,
  output logic                    done
);

  localparam int BW = 4 * BCD_DIGITS;
  localparam int IW = $clog2(MV_W);
  localparam logic [IW-1:0] LAST = IW'(MV_W - 1);

  logic [BW-1:0] r_bcd;
  logic [IW-1:0] r_iter;
  logic          r_active;
  logic [BW-1:0] w_adj;
  logic [IW-1:0] w_idx;

  always_comb begin
    w_adj = r_bcd;
    for (int d = 0; d < BCD_DIGITS; d++) begin
      if (r_bcd[4*d +: 4] >= 4'd5) begin
        w_adj[4*d +: 4] = r_bcd[4*d +: 4] + 4'd3;
      end
    end
  end

  // Walk bin_in from its MSB down instead of keeping a shifted copy of it.
  assign w_idx = LAST - r_iter;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_bcd    <= '0;
      r_iter   <= '0;
      r_active <= 1'b0;
    end else if (start) begin
      r_bcd    <= '0;
      r_iter   <= '0;
      r_active <= 1'b1;
    end else if (r_active) begin
      r_bcd  <= (w_adj << 1) | BW'(bin_in[w_idx]);
      r_iter <= r_iter + 1'b1;
      if (r_iter == LAST) begin
        r_active <= 1'b0;
      end
    end
  end

  assign bcd_out = r_bcd;
  assign done    = r_active && (r_iter == LAST);

endmodule

// File: rtl/adc_bcd_convert.sv
// ADC code -> millivolts -> four BCD digits; digits and adc_data_ready update 16 cycles after accept.
// No queueing: adc_valid while busy is discarded and flagged on sample_dropped.
module adc_bcd_convert
  import adc_bcd_pkg::*;
#(
  parameter int ADC_W   = ADC_W_DEF,
  parameter int VREF_MV = VREF_MV_DEF,
  parameter int MV_W    = MV_W_DEF
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [ADC_W-1:0] adc_data,
  input  logic             adc_valid,
  output logic [3:0]       thousands,
  output logic [3:0]       hundreds,
  output logic [3:0]       tens,
  output logic [3:0]       ones,
  output logic             adc_data_ready,
  output logic             busy,
  output logic             sample_dropped
);

  if (VREF_MV > 9999 || (2 ** MV_W) <= 9999) begin : g_bad_cfg
    $error("adc_bcd_convert: VREF_MV must be <= 9999 and MV_W must hold 9999");
  end

  localparam logic [MV_W-1:0] VREF_V = MV_W'(VREF_MV);

  conv_state_t             r_state;
  logic [ADC_W-1:0]        r_code;
  logic [MV_W-1:0]         r_mv;
  logic [3:0]              r_thou, r_hund, r_tens, r_ones;
  logic                    r_ready;
  logic                    r_drop;
  logic [ADC_W+MV_W-1:0]   w_prod;
  logic [MV_W-1:0]         w_mv;
  logic [4*BCD_DIGITS-1:0] w_bcd;
  logic                    w_done;
  logic                    w_start;

  // Full-width unsigned product, truncated by the shift: result is always below VREF_MV.
  assign w_prod  = {{MV_W{1'b0}}, r_code} * {{ADC_W{1'b0}}, VREF_V};
  assign w_mv    = MV_W'(w_prod >> ADC_W);
  assign w_start = (r_state == SCALE);

  bin2bcd_seq #(.MV_W(MV_W)) u_bin2bcd (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (w_start),
    .bin_in  (r_mv),
    .bcd_out (w_bcd),
    .done    (w_done)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_code  <= '0;
      r_mv    <= '0;
      r_thou  <= '0;
      r_hund  <= '0;
      r_tens  <= '0;
      r_ones  <= '0;
      r_ready <= 1'b0;
      r_drop  <= 1'b0;
    end else begin
      r_ready <= 1'b0;
      r_drop  <= adc_valid && (r_state != IDLE);
      case (r_state)
        IDLE: begin
          if (adc_valid) begin
            r_code  <= adc_data;
            r_state <= SCALE;
          end
        end
        SCALE: begin
          r_mv    <= w_mv;
          r_state <= CONVERT;
        end
        CONVERT: begin
          if (w_done) begin
            r_state <= DONE;
          end
        end
        DONE: begin
          r_thou  <= w_bcd[15:12];
          r_hund  <= w_bcd[11:8];
          r_tens  <= w_bcd[7:4];
          r_ones  <= w_bcd[3:0];
          r_ready <= 1'b1;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign thousands      = r_thou;
  assign hundreds       = r_hund;
  assign tens           = r_tens;
  assign ones           = r_ones;
  assign adc_data_ready = r_ready;
  assign sample_dropped = r_drop;
  assign busy           = (r_state != IDLE);

endmodule

// File: tb/tb_adc_bcd_convert.sv
// Bench for adc_bcd_convert: timing/value model compared every cycle, plus directed literal cases.
module tb_adc_bcd_convert;

  localparam int VREF = 5000;

  logic        clk       = 1'b0;
  logic        reset_n   = 1'b1;
  logic        adc_valid = 1'b0;
  logic [11:0] adc_data  = '0;
  logic [3:0]  thousands, hundreds, tens, ones;
  logic        adc_data_ready, busy, sample_dropped;

  int errors = 0;
  int checks = 0;

  adc_bcd_convert dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .adc_data       (adc_data),
    .adc_valid      (adc_valid),
    .thousands      (thousands),
    .hundreds       (hundreds),
    .tens           (tens),
    .ones           (ones),
    .adc_data_ready (adc_data_ready),
    .busy           (busy),
    .sample_dropped (sample_dropped)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int model_mv(input int unsigned code);
    return int'((code * VREF) / 4096);
  endfunction

  function automatic int bcd_of(input int v);
    return ((v / 1000) % 10) * 4096 + ((v / 100) % 10) * 256 + ((v / 10) % 10) * 16 + (v % 10);
  endfunction

  // Model: a sample is taken when at least 17 edges have passed since the last accepted
  // one; it is busy for the 16 edges after acceptance and reports on the 16th.
  int n     = 0;
  int acc   = -1000;
  int pend  = 0;
  int shown = 0;
  bit e_drop, e_busy, e_rdy;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      n = 0; acc = -1000; pend = 0; shown = 0;
      e_drop = 0; e_busy = 0; e_rdy = 0;
    end else begin
      n++;
      e_drop = 0;
      if (adc_valid) begin
        if (n - acc >= 17) begin
          acc  = n;
          pend = model_mv(adc_data);
        end else begin
          e_drop = 1;
        end
      end
      e_busy = (n - acc) < 16;
      e_rdy  = (n - acc) == 16;
      if (e_rdy) shown = pend;
    end
  end

  always @(negedge clk) begin
    if (reset_n) begin
      chk("cyc_ready", adc_data_ready, e_rdy);
      chk("cyc_busy", busy, e_busy);
      chk("cyc_drop", sample_dropped, e_drop);
      chk("cyc_digits", {thousands, hundreds, tens, ones}, bcd_of(shown));
    end
  end

  // Caller sits at a negedge; the valid cycle is sampled on the next posedge.
  task automatic send(input int code);
    adc_data  = 12'(code);
    adc_valid = 1'b1;
    @(negedge clk);
    adc_valid = 1'b0;
    adc_data  = 12'($urandom_range(0, 4095));
  endtask

  task automatic wait_ready(input string name, input int exp_bcd, input int exp_lat);
    int k = 0;
    while (!adc_data_ready && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk({name, "_seen"}, adc_data_ready, 1);
    if (exp_lat >= 0) chk({name, "_latency"}, k, exp_lat);
    chk({name, "_digits"}, {thousands, hundreds, tens, ones}, exp_bcd);
  endtask

  task automatic count_ready(input int cycles, output int cnt);
    cnt = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (adc_data_ready) cnt++;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int cnt;

    chk("model_4095", model_mv(4095), 4998);
    chk("model_819", model_mv(819), 999);
    chk("model_1000", model_mv(1000), 1220);

    #2 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_digits", {thousands, hundreds, tens, ones}, 0);
    chk("rst_ready", adc_data_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_drop", sample_dropped, 0);
    reset_n = 1'b1;
    @(negedge clk);

    send(0);    wait_ready("code0", 'h0000, 16);
    @(negedge clk);
    chk("code0_ready_one_cycle", adc_data_ready, 0);
    send(4095); wait_ready("code4095", 'h4998, 16);
    send(2048); wait_ready("code2048", 'h2500, 16);
    send(819);  wait_ready("code819", 'h0999, 16);

    // Second sample arrives mid-conversion and must be discarded.
    send(1234);
    repeat (4) @(negedge clk);
    adc_data  = 12'd4000;
    adc_valid = 1'b1;
    @(negedge clk);
    adc_valid = 1'b0;
    chk("drop_pulse", sample_dropped, 1);
    wait_ready("drop_first", 'h1506, -1);
    count_ready(25, cnt);
    chk("drop_single_ready", cnt, 0);

    // Abort mid-conversion.
    send(3000);
    repeat (7) @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("abort_digits", {thousands, hundreds, tens, ones}, 0);
    chk("abort_ready", adc_data_ready, 0);
    chk("abort_busy", busy, 0);
    chk("abort_drop", sample_dropped, 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    count_ready(25, cnt);
    chk("abort_no_ready", cnt, 0);
    send(2048); wait_ready("after_abort", 'h2500, 16);

    // Back-to-back: next sample presented in the cycle right after the ready edge.
    @(negedge clk);
    send(1000); wait_ready("b2b_1000", 'h1220, 16);
    send(3000); wait_ready("b2b_3000", 'h3662, 16);

    for (int i = 0; i < 1500; i++) begin
      adc_valid = ($urandom_range(0, 5) == 0);
      case ($urandom_range(0, 7))
        0:       adc_data = 12'd0;
        1:       adc_data = 12'd4095;
        default: adc_data = 12'($urandom_range(0, 4095));
      endcase
      @(negedge clk);
    end
    adc_valid = 1'b0;
    repeat (20) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/adc_bcd_convert.md
# adc_bcd_convert

Converts each raw 12-bit ADC sample into a millivolt value and then into four BCD digits, formatted as X.XXX volts. It sits between the ADC sampling logic and `uart_send`, on the fast `clk` domain. It drives `uart_send`'s `thousands/hundreds/tens/ones` digit inputs and its one-cycle `adc_data_ready` strobe.

## Interface
Parameters:
- `ADC_W`, 12: ADC code width.
- `VREF_MV`, 5000: full-scale reference in mV; must be ≤ 9999 (static assertion at elaboration).
- `MV_W`, 14: width of the millivolt value; must hold 9999.

Ports:
- `clk`  in  1  single clock; the fast clock that `uart_send` also uses for its toggle synchronizer.
- `reset_n`  in  1  asynchronous, active-low reset.
- `adc_data`  in  ADC_W  sample code; valid only while `adc_valid`=1.
- `adc_valid`  in  1  one-cycle strobe qualifying `adc_data`.
- `thousands`, `hundreds`, `tens`, `ones`  out  4 each  registered BCD digits.
- `adc_data_ready`  out  1  one-`clk`-cycle pulse; new digits are valid.
- `busy`  out  1  high while a conversion is in progress.
- `sample_dropped`  out  1  one-cycle pulse; `adc_valid` arrived while busy.

## Operation
- FSM states: IDLE, SCALE, CONVERT, DONE.
- **IDLE**
  - On `adc_valid`=1: register `adc_data` into `code_r` and go to SCALE.
  - Otherwise stay in IDLE.
- **SCALE** (1 cycle)
  - `mv_r <= (code_r * VREF_MV) >> ADC_W`.
  - The product is ADC_W+MV_W bits wide, unsigned, truncating (no rounding). The result is always < VREF_MV.
  - Clear the 16-bit BCD shift register and set `iter` to 0, then go to CONVERT.
- **CONVERT** (exactly MV_W = 14 cycles), double-dabble, MSB first. Each cycle:
  - Add 3 to every BCD nibble ≥ 5.
  - Shift {bcd, mv} left by 1.
  - `iter++`.
  - When `iter`=13 is processed, go to DONE.
- **DONE** (1 cycle)
  - Load `thousands..ones` from the BCD register, most significant nibble first.
  - Set `adc_data_ready` to 1 and go to IDLE.
  - `adc_data_ready` clears on the following edge.
- `busy` = (state != IDLE), decoded combinationally from the state register.
- `sample_dropped` registered pulse: set for 1 cycle on any edge where `adc_valid`=1 and state != IDLE. The sample is discarded, with no queueing.
- The digit outputs hold their value until the next DONE.

## Timing
- Reset values: all digits 0, `adc_data_ready`=0, `sample_dropped`=0, state=IDLE, `busy`=0. Internal `code_r`, `mv_r`, BCD register and `iter` are all 0.
- Latency: `adc_valid` is sampled at edge e0.
  - Digits update and `adc_data_ready` goes high at e16.
  - `adc_data_ready` goes low at e17.
  - It is high for exactly one cycle. This is required because `uart_send` toggles once per high cycle.
- `busy` is high from after e0 through e16; it is low in the cycle following e16.
- Throughput: an `adc_valid` presented in the cycle after e16 is accepted. Minimum spacing between accepted samples is 17 cycles.
- If `adc_valid` arrives in the same cycle as the state is DONE, it is dropped and `sample_dropped` pulses.
- Reset mid-conversion: the asynchronous abort forces all reset values immediately. No `adc_data_ready` is produced for the aborted sample.
- Boundary codes:
  - Code 0 gives 0.000.
  - Code 2^ADC_W−1 gives floor((4095·VREF_MV)/4096), never VREF_MV itself.

## Structure
- `adc_bcd_pkg` holds:
  - the state enum `conv_state_t` (IDLE, SCALE, CONVERT, DONE);
  - `ADC_W_DEF`, `MV_W_DEF`, `VREF_MV_DEF`;
  - `BCD_DIGITS` = 4.
- One sub-module: `bin2bcd_seq` (MV_W-bit iterative double-dabble engine).
  - Signals: `start`, `bin_in`, `bcd_out[15:0]`, `done`.
  - It owns `iter` and the shift register.
- The top level owns the FSM, the scaling multiply, the output registers and the drop detection.

## Test plan
- Reset, then `adc_data`=0 with `adc_valid` → at e16, digits 0,0,0,0 and `adc_data_ready` high for exactly 1 cycle.
- `adc_data`=4095, VREF_MV=5000 → digits 4,9,9,8.
- `adc_data`=2048 → 2,5,0,0. `adc_data`=819 → 0,9,9,9, which checks truncation (999.75 → 999).
- `adc_valid` at e0, then again at e5 → `sample_dropped` pulses at e5. Exactly one `adc_data_ready`, and the digits come from the first sample.
- Assert `reset_n` low at e8 mid-CONVERT → all outputs 0 immediately, no `adc_data_ready`. After release, a new sample converts correctly.
- Back-to-back samples 1000 and 3000, each presented in the first IDLE cycle after the previous DONE → digits 1,2,2,0 (1000·5000/4096 = 1220.7) then 3,6,6,2 (3662.1), with no drops.
